pipe_seg_ctrl: RTL
==================

Name: pipe_seg_ctrl

Overview:
- Central sequencer for the five-stage pipeline segment registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-stage enable and flush strobes from:
  - run/step control from the debug unit,
  - load-use hazard detection,
  - branch-taken redirect,
  - HALT propagation.
- Also counts advancing cycles for the debug unit.

Parameters:
- REG_ADDR_SIZE, 5, width of register-file addresses compared for hazards
- CNT_SIZE, 32, width of the advancing-cycle counter

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-low reset
- i_start  in  1  one-cycle pulse; leaves IDLE
- i_run_mode  in  1  1 = continuous run, 0 = single-step (sampled on i_start)
- i_step  in  1  one-cycle pulse; advances pipeline one cycle in step mode
- i_id_ex_mem_read  in  1  instruction in ID/EX is a load
- i_id_ex_rt  in  REG_ADDR_SIZE  load destination in ID/EX
- i_if_id_rs  in  REG_ADDR_SIZE  rs of instruction in IF/ID
- i_if_id_rt  in  REG_ADDR_SIZE  rt of instruction in IF/ID
- i_branch_taken  in  1  branch/jump resolved taken in ID
- i_halt_id  in  1  HALT decoded in ID
- i_halt_wb  in  1  HALT reached MEM/WB output
- o_en_pc, o_en_if_id, o_en_id_ex, o_en_ex_mem, o_en_mem_wb  out  1 each  stage enables
- o_flush_if_id, o_flush_id_ex  out  1 each  bubble insertion
- o_state  out  3  FSM state encoding
- o_cycle_count  out  CNT_SIZE  advancing cycles since reset
- o_halted  out  1  pipeline drained after HALT

Behaviour:
- Reset (i_reset=0 at clock edge):
  - state=IDLE, pc_freeze=0, o_cycle_count=0, o_halted=0.
  - All enables/flushes 0 while in IDLE.
- States and encodings: IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, HALTED=4.
- IDLE:
  - i_start=1 and i_run_mode=1 -> RUN.
  - i_start=1 and i_run_mode=0 -> STEP_WAIT.
  - i_start is ignored in every other state.
- STEP_WAIT:
  - All enables 0.
  - i_step=1 -> STEP_EXEC.
- STEP_EXEC:
  - Exactly one advancing cycle, then -> STEP_WAIT.
  - i_step during STEP_EXEC is ignored (no queuing).
- Advancing cycle (RUN or STEP_EXEC):
  - Default: all five enables 1, flushes 0.
  - Load-use stall when i_id_ex_mem_read=1, i_id_ex_rt!=0, and i_id_ex_rt equals i_if_id_rs or i_if_id_rt:
    - o_en_pc=0, o_en_if_id=0, o_flush_id_ex=1.
    - EX/MEM and MEM/WB stay enabled.
  - Branch taken with no stall: o_flush_if_id=1.
  - Stall and branch together: stall wins, o_flush_if_id=0 (branch re-evaluated next cycle).
  - i_halt_id=1 on a non-stalled advancing cycle sets sticky pc_freeze.
  - While pc_freeze=1: o_en_pc=0 and o_flush_if_id=1; later stages keep draining.
  - o_cycle_count increments by 1 every advancing cycle, stalled or not. It wraps at 2^CNT_SIZE-1 -> 0.
- HALT completion:
  - i_halt_wb=1 during an advancing cycle -> HALTED on the next edge.
  - The MEM/WB write of that cycle still occurs (o_en_mem_wb=1).
- HALTED:
  - All enables 0, flushes 0, o_halted=1.
  - Exits only via reset.
- Timing:
  - Enable/flush outputs are combinational from registered state, pc_freeze and current hazard inputs, so they act in the same cycle.
  - o_state, o_cycle_count and o_halted are registered.
- Reset asserted mid-RUN or mid-STEP_EXEC: next cycle everything is in reset values, with no partial advance.

Optional Feature:
- Macro: PIPE_SEG_CTRL_STEP_EN.
- Defined:
  - Single-step states STEP_WAIT/STEP_EXEC are present.
  - i_step and i_run_mode behave as described above.
- Undefined:
  - STEP states are not built.
  - i_start always -> RUN regardless of i_run_mode.
  - i_step and i_run_mode are ignored.
  - o_state never shows 2 or 3.

Test Plan:
- Reset then i_start with i_run_mode=1:
  - Cycle after start: state=1, all enables 1.
  - After 10 cycles: o_cycle_count=10.
- RUN, i_id_ex_mem_read=1, i_id_ex_rt=5, i_if_id_rs=5 for 1 cycle:
  - o_en_pc=0, o_en_if_id=0, o_flush_id_ex=1, o_en_ex_mem=1.
  - Same case with i_id_ex_rt=0: no stall.
- RUN, stall condition plus i_branch_taken=1 in the same cycle:
  - o_flush_if_id=0.
  - Next cycle, no stall and branch still taken: o_flush_if_id=1.
- RUN, i_halt_id pulse at cycle 20, i_halt_wb at cycle 23:
  - o_en_pc=0 from cycle 20 on.
  - o_halted=1 and state=4 at cycle 24.
  - Enables all 0 thereafter.
  - i_start ignored afterwards.
- Step mode (macro defined), start with i_run_mode=0, three i_step pulses 5 cycles apart:
  - Exactly 3 single cycles with enables=1.
  - o_cycle_count=3.
- Assert i_reset=0 during RUN with o_cycle_count=7:
  - Next cycle: state=0, count=0, all enables 0.

Source files
------------

// File: rtl/pipe_seg_ctrl_if.sv
// Purpose: bundles the sequencer's control inputs and stage enable/flush outputs.
// Latency: n/a (wiring only).
// Backpressure: n/a; the stage enables themselves are the pipeline's stall mechanism.
//
// Ports (modports):
//   master - the sequencer: reads run/step/hazard/halt inputs, drives enables, flushes and status.
//   slave  - the pipeline/debug side: drives the inputs, consumes enables, flushes and status.
interface pipe_seg_ctrl_if #(
  parameter int REG_ADDR_SIZE = 5,
  parameter int CNT_SIZE      = 32
);
  // debug-unit run control
  logic                     i_start;
  logic                     i_run_mode;
  logic                     i_step;
  // hazard / redirect / halt sources
  logic                     i_id_ex_mem_read;
  logic [REG_ADDR_SIZE-1:0] i_id_ex_rt;
  logic [REG_ADDR_SIZE-1:0] i_if_id_rs;
  logic [REG_ADDR_SIZE-1:0] i_if_id_rt;
  logic                     i_branch_taken;
  logic                     i_halt_id;
  logic                     i_halt_wb;
  // stage enables and bubble strobes
  logic                     o_en_pc;
  logic                     o_en_if_id;
  logic                     o_en_id_ex;
  logic                     o_en_ex_mem;
  logic                     o_en_mem_wb;
  logic                     o_flush_if_id;
  logic                     o_flush_id_ex;
  // status
  logic [2:0]               o_state;
  logic [CNT_SIZE-1:0]      o_cycle_count;
  logic                     o_halted;

  modport master (
    input  i_start, i_run_mode, i_step,
    input  i_id_ex_mem_read, i_id_ex_rt, i_if_id_rs, i_if_id_rt,
    input  i_branch_taken, i_halt_id, i_halt_wb,
    output o_en_pc, o_en_if_id, o_en_id_ex, o_en_ex_mem, o_en_mem_wb,
    output o_flush_if_id, o_flush_id_ex,
    output o_state, o_cycle_count, o_halted
  );

  modport slave (
    output i_start, i_run_mode, i_step,
    output i_id_ex_mem_read, i_id_ex_rt, i_if_id_rs, i_if_id_rt,
    output i_branch_taken, i_halt_id, i_halt_wb,
    input  o_en_pc, o_en_if_id, o_en_id_ex, o_en_ex_mem, o_en_mem_wb,
    input  o_flush_if_id, o_flush_id_ex,
    input  o_state, o_cycle_count, o_halted
  );
endinterface

// File: rtl/pipe_seg_ctrl.sv
// Purpose: sequencer for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB segment registers.
// Latency: enables/flushes are combinational (same cycle); state, cycle count and halted are registered.
// Backpressure: load-use stall holds PC and IF/ID and bubbles ID/EX; later stages keep draining.
//
// Ports: i_clk (clock), i_reset (synchronous, active-low), bus (pipe_seg_ctrl_if.master):
//   run/step control, load-use operands, branch/halt strobes in; stage enables, flushes,
//   o_state, o_cycle_count and o_halted out.
// Build option: define PIPE_SEG_CTRL_STEP_EN to include single-step states STEP_WAIT/STEP_EXEC;
//   without it i_start always enters RUN and i_step/i_run_mode are ignored.
module pipe_seg_ctrl #(
  parameter int REG_ADDR_SIZE = 5,
  parameter int CNT_SIZE      = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  pipe_seg_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
`ifdef PIPE_SEG_CTRL_STEP_EN
    ST_STEP_WAIT = 3'd2,
    ST_STEP_EXEC = 3'd3,
`endif
    ST_HALTED    = 3'd4
  } state_t;

  localparam logic [CNT_SIZE-1:0] CNT_ONE = CNT_SIZE'(1);

  state_t                state_q, state_d;
  logic                  pc_freeze_q, pc_freeze_d;
  logic [CNT_SIZE-1:0]   cycle_count_q;
  logic                  halted_q;
  logic                  advancing;
  logic                  stall;
  logic                  freeze_now;

  logic [REG_ADDR_SIZE-1:0] ex_rt;
  logic [REG_ADDR_SIZE-1:0] if_rs;
  logic [REG_ADDR_SIZE-1:0] if_rt;

  assign ex_rt = bus.i_id_ex_rt;
  assign if_rs = bus.i_if_id_rs;
  assign if_rt = bus.i_if_id_rt;

`ifndef PIPE_SEG_CTRL_STEP_EN
  // Step controls have no effect in a run-only build.
  logic unused_step_inputs;
  assign unused_step_inputs = bus.i_step ^ bus.i_run_mode;
`endif

  // Load-use: the load result is not ready for the instruction now in IF/ID.
  // Register 0 is hard-wired so it never creates a dependency.
  assign stall = bus.i_id_ex_mem_read && (ex_rt != '0) &&
                 ((ex_rt == if_rs) || (ex_rt == if_rt));

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q       <= ST_IDLE;
      pc_freeze_q   <= 1'b0;
      cycle_count_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_freeze_q <= pc_freeze_d;
      if (advancing) begin
        cycle_count_q <= cycle_count_q + CNT_ONE;
      end
      halted_q    <= (state_d == ST_HALTED);
    end
  end

  always_comb begin
    state_d           = state_q;
    pc_freeze_d       = pc_freeze_q;
    advancing         = 1'b0;
    freeze_now        = 1'b0;
    bus.o_en_pc       = 1'b0;
    bus.o_en_if_id    = 1'b0;
    bus.o_en_id_ex    = 1'b0;
    bus.o_en_ex_mem   = 1'b0;
    bus.o_en_mem_wb   = 1'b0;
    bus.o_flush_if_id = 1'b0;
    bus.o_flush_id_ex = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
`ifdef PIPE_SEG_CTRL_STEP_EN
          state_d = bus.i_run_mode ? ST_RUN : ST_STEP_WAIT;
`else
          state_d = ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        advancing = 1'b1;
        if (bus.i_halt_wb) begin
          state_d = ST_HALTED;
        end
      end
`ifdef PIPE_SEG_CTRL_STEP_EN
      ST_STEP_WAIT: begin
        if (bus.i_step) begin
          state_d = ST_STEP_EXEC;
        end
      end
      ST_STEP_EXEC: begin
        // One advancing cycle only; a step pulse seen here is dropped.
        advancing = 1'b1;
        state_d   = bus.i_halt_wb ? ST_HALTED : ST_STEP_WAIT;
      end
`endif
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A reset cycle must not move any segment register.
    if (!i_reset) begin
      advancing = 1'b0;
    end

    if (advancing) begin
      bus.o_en_pc     = 1'b1;
      bus.o_en_if_id  = 1'b1;
      bus.o_en_id_ex  = 1'b1;
      bus.o_en_ex_mem = 1'b1;
      bus.o_en_mem_wb = 1'b1;

      // HALT in ID freezes fetch from this very cycle, so nothing after it is fetched.
      freeze_now = pc_freeze_q || (bus.i_halt_id && !stall);
      if (bus.i_halt_id && !stall) begin
        pc_freeze_d = 1'b1;
      end

      if (stall) begin
        // Hold PC and IF/ID, bubble ID/EX. A simultaneous branch is dropped
        // here and resolved again once the operand is available.
        bus.o_en_pc       = 1'b0;
        bus.o_en_if_id    = 1'b0;
        bus.o_flush_id_ex = 1'b1;
      end else begin
        if (bus.i_branch_taken) begin
          bus.o_flush_if_id = 1'b1;
        end
        if (freeze_now) begin
          // Keep feeding bubbles behind HALT while the rest drains.
          bus.o_en_pc       = 1'b0;
          bus.o_flush_if_id = 1'b1;
        end
      end
    end
  end

  assign bus.o_state       = state_q;
  assign bus.o_cycle_count = cycle_count_q;
  assign bus.o_halted      = halted_q;

endmodule
